// File: rtl/stream_join_pkg.sv
// Shared helpers for the stream_join block: payload width of the joined beat.
package stream_join_pkg;

  // Joined payload carries {last, a_data, b_data}.
  function automatic int join_w(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/stream_join_slice.sv
// Generic valid/ready register slice. Define STREAM_JOIN_SKID_EN to add a
// second (skid) entry so in_ready comes from a flop instead of out_ready.
module stream_join_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         out_vld;
  logic [W-1:0] out_dat;
  logic         free;

  assign free      = !out_vld || out_ready;
  assign out_valid = out_vld;
  assign out_data  = out_dat;

`ifdef STREAM_JOIN_SKID_EN
  logic         skid_vld;
  logic [W-1:0] skid_dat;
  logic         in_fire;

  // Accept whenever the skid entry is empty; a beat arriving while the
  // output stalls parks in skid and is issued before any newer beat.
  assign in_ready = !skid_vld;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (free) begin
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_dat  <= skid_dat;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        out_vld <= 1'b1;
        out_dat <= in_data;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_vld <= 1'b1;
      skid_dat <= in_data;
    end
  end
`else
  assign in_ready = free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (free) begin
      out_vld <= in_valid;
      if (in_valid) out_dat <= in_data;
    end
  end
`endif

endmodule

// File: rtl/stream_join.sv
// Joins streams A and B into one registered stream C ({a_data, b_data}).
// STREAM_JOIN_SKID_EN selects a skid-buffered output stage.
module stream_join
  import stream_join_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int HA_LAST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic                 a_last,
  input  logic [DATA_WD-1:0]   a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [DATA_WD-1:0]   b_data,
  output logic                 b_ready,
  output logic                 c_valid,
  output logic                 c_last,
  output logic [2*DATA_WD-1:0] c_data,
  input  logic                 c_ready
);

  localparam int PW = join_w(DATA_WD);

  logic          slot_ready;
  logic          last;
  logic [PW-1:0] in_pay;
  logic [PW-1:0] out_pay;

  // Each side is ready only when its peer is valid, so A and B fire together.
  assign a_ready = b_valid && slot_ready;
  assign b_ready = a_valid && slot_ready;

  assign last   = (HA_LAST != 0) ? a_last : 1'b1;
  assign in_pay = {last, a_data, b_data};

  stream_join_slice #(.W(PW)) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid && b_valid),
    .in_ready  (slot_ready),
    .in_data   (in_pay),
    .out_valid (c_valid),
    .out_data  (out_pay),
    .out_ready (c_ready)
  );

  assign c_last = out_pay[PW-1];
  assign c_data = out_pay[2*DATA_WD-1:0];

endmodule

// File: tb/tb_stream_join.sv
// Self-checking bench for stream_join: directed scenarios plus a randomized
// run scored against a zip-of-A-and-B queue model.
module tb_stream_join;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_valid, a_last, b_valid, c_ready;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, c_valid, c_last;
  logic [2*DW-1:0] c_data;
  logic          a_ready2, b_ready2, c_valid2, c_last2;
  logic [2*DW-1:0] c_data2;

  stream_join #(.DATA_WD(DW), .HA_LAST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_last(a_last), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_last(c_last), .c_data(c_data), .c_ready(c_ready)
  );

  // Same stimulus, packet boundary disabled: every C beat must be last.
  stream_join #(.DATA_WD(DW), .HA_LAST(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_last(a_last), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
    .c_valid(c_valid2), .c_last(c_last2), .c_data(c_data2), .c_ready(c_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: C must be the pairwise zip of accepted A and B beats.
  logic [DW:0]   qa[$];
  logic [DW-1:0] qb[$];
  logic          af, bf, hold;
  logic [2*DW:0] hold_val;
  logic [DW:0]   ea;
  logic [DW-1:0] eb;

  initial hold = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      hold = 1'b0;
    end else begin
      af = a_valid && a_ready;
      bf = b_valid && b_ready;
      if (af || bf) begin
        n_cmp++;
        if (af !== bf) begin
          n_err++;
          $display("FAIL fire_pair: a_fire=%b b_fire=%b expected equal", af, bf);
        end
      end
      if (af) qa.push_back({a_last, a_data});
      if (bf) qb.push_back(b_data);
      if (hold) begin
        n_cmp++;
        if (!c_valid || {c_last, c_data} !== hold_val) begin
          n_err++;
          $display("FAIL hold_stable: valid=%b got=%h expected valid=1 %h",
                   c_valid, {c_last, c_data}, hold_val);
        end
      end
      hold     = c_valid && !c_ready;
      hold_val = {c_last, c_data};
      if (c_valid && c_ready) begin
        n_cmp++;
        if (qa.size() == 0 || qb.size() == 0) begin
          n_err++;
          $display("FAIL c_unexpected: got=%h with no pending A/B pair", {c_last, c_data});
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          if ({c_last, c_data} !== {ea, eb}) begin
            n_err++;
            $display("FAIL c_beat: got=%h expected=%h", {c_last, c_data}, {ea, eb});
          end
        end
      end
      if (c_valid2) begin
        n_cmp++;
        if (c_last2 !== 1'b1 || c_data2 !== c_data) begin
          n_err++;
          $display("FAIL no_last_mode: last=%b data=%h expected last=1 data=%h",
                   c_last2, c_data2, c_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 0; b_valid = 0; a_last = 0;
    a_data = '0; b_data = '0; c_ready = 1'b1;
    #100;
    n_cmp++;
    if ({c_valid, c_last, c_data} !== '0) begin
      n_err++;
      $display("FAIL reset_out: got v=%b l=%b d=%h expected all 0", c_valid, c_last, c_data);
    end
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready_idle: got %b%b expected 00", a_ready, b_ready);
    end
    #3 rst_n = 1'b1;
    step();
    a_valid = 1; b_valid = 1; a_data = 4'h1; b_data = 4'h2;
    #1;
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_both_valid: got %b%b expected 11", a_ready, b_ready);
    end
    step();
    a_valid = 0; b_valid = 0;
    n_cmp++;
    if (!c_valid || c_data !== 8'h12) begin
      n_err++;
      $display("FAIL first_beat: got v=%b d=%h expected v=1 d=12", c_valid, c_data);
    end
    step();
    n_cmp++;
    if (c_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_idle: got v=%b expected 0", c_valid);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] v;
    c_ready = 1'b1;
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 20; i++) begin
      v = DW'(i);
      a_data = v; b_data = v; a_last = (v == 4'hF);
      step();
      n_cmp++;
      if (!c_valid || c_data !== {v, v} || c_last !== (v == 4'hF)) begin
        n_err++;
        $display("FAIL stream_%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 i, c_valid, c_last, c_data, (v == 4'hF), {v, v});
      end
    end
    a_valid = 0; b_valid = 0; a_last = 0;
    step();
  endtask

  task automatic test_one_sided();
    c_ready = 1'b1;
    a_valid = 1; a_data = 4'h3; a_last = 0; b_valid = 0; b_data = 4'h9;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (a_ready !== 1'b0 || c_valid !== 1'b0) begin
        n_err++;
        $display("FAIL one_sided_%0d: a_ready=%b c_valid=%b expected 0 0", k, a_ready, c_valid);
      end
      step();
    end
    b_valid = 1;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL one_sided_join_ready: a_ready=%b expected 1", a_ready);
    end
    step();
    a_valid = 0; b_valid = 0;
    n_cmp++;
    if (!c_valid || c_data !== 8'h39 || c_last !== 1'b0) begin
      n_err++;
      $display("FAIL one_sided_beat: got v=%b l=%b d=%h expected v=1 l=0 d=39",
               c_valid, c_last, c_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic took, exp_rdy;
    c_ready = 1'b0;
    a_valid = 1; b_valid = 1; a_last = 0; a_data = 4'h5; b_data = 4'h6;
    step();
    a_data = 4'h7; b_data = 4'h8;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef STREAM_JOIN_SKID_EN
      exp_rdy = (k == 0);
`else
      exp_rdy = 1'b0;
`endif
      n_cmp++;
      if (a_ready !== exp_rdy || b_ready !== exp_rdy || !c_valid || c_data !== 8'h56) begin
        n_err++;
        $display("FAIL bp_hold_%0d: rdy=%b%b v=%b d=%h expected rdy=%b v=1 d=56",
                 k, a_ready, b_ready, c_valid, c_data, exp_rdy);
      end
      took = a_ready;
      step();
      if (took) begin a_data = 4'h9; b_data = 4'hA; end
    end
    c_ready = 1'b1;
    step();
`ifdef STREAM_JOIN_SKID_EN
    n_cmp++;
    if (!c_valid || c_data !== 8'h78) begin
      n_err++;
      $display("FAIL bp_release0: got v=%b d=%h expected v=1 d=78", c_valid, c_data);
    end
    step();
    a_valid = 0; b_valid = 0;
    n_cmp++;
    if (!c_valid || c_data !== 8'h9A) begin
      n_err++;
      $display("FAIL bp_release1: got v=%b d=%h expected v=1 d=9a", c_valid, c_data);
    end
`else
    a_valid = 0; b_valid = 0;
    n_cmp++;
    if (!c_valid || c_data !== 8'h78) begin
      n_err++;
      $display("FAIL bp_release0: got v=%b d=%h expected v=1 d=78", c_valid, c_data);
    end
`endif
    step();
    n_cmp++;
    if (c_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drained: got v=%b expected 0", c_valid);
    end
  endtask

  task automatic test_random();
    logic afl, bfl;
    a_valid = 0; b_valid = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      afl = a_valid && a_ready;
      bfl = b_valid && b_ready;
      step();
      if (!a_valid || afl) begin
        a_valid = 1'($urandom_range(0, 1));
        a_data  = DW'($urandom);
        a_last  = 1'($urandom);
      end
      if (!b_valid || bfl) begin
        b_valid = 1'($urandom_range(0, 1));
        b_data  = DW'($urandom);
      end
      c_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    afl = a_valid && a_ready;
    step();
    a_valid = 0; b_valid = 0; c_ready = 1'b1;
    for (int k = 0; k < 10 && c_valid; k++) step();
    n_cmp++;
    if (c_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout: c_valid=%b expected 0 within 10 cycles", c_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL lost_beats: pending a=%0d b=%0d expected 0 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_one_sided();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
